// File: rtl/bsg_manycore_block_mem_amo_unit.sv
//------------------------------------------------------------------------------
// Module  : bsg_manycore_block_mem_amo_unit
// Brief   : Serialising request unit in front of the block-mem SRAM macro.
//           Executes LOAD/STORE directly and AMOs (swap/add/or/and, plus
//           optional signed min/max) as a locked read-modify-write, returning
//           one response per request on a valid/ready channel.
// Config  : BSG_MANYCORE_BMEM_AMO_MINMAX_EN enables AMOMIN/AMOMAX (ops 6/7);
//           without it those ops run as LOAD and flag err_o.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_manycore_block_mem_amo_unit #(
  parameter  int data_width_p        = 32,
  parameter  int mem_size_in_words_p = 1024,
  localparam int addr_width_lp       = `BSG_SAFE_CLOG2(mem_size_in_words_p),
  localparam int mask_width_lp       = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [2:0]               op_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] mask_i,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [data_width_p-1:0]  mem_data_o,
  output logic [mask_width_lp-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]  mem_data_i,

  output logic                     v_o,
  output logic [data_width_p-1:0]  data_o,
  output logic                     err_o,
  input  logic                     ready_i
);

  localparam logic [2:0] c_op_load = 3'd0;
  localparam logic [2:0] c_op_store = 3'd1;
  localparam logic [2:0] c_op_swap = 3'd2;
  localparam logic [2:0] c_op_add = 3'd3;
  localparam logic [2:0] c_op_or = 3'd4;
  localparam logic [2:0] c_op_and = 3'd5;
  localparam logic [2:0] c_op_min = 3'd6;
  localparam logic [2:0] c_op_max = 3'd7;

  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_issue = 2'd1;
  localparam logic [1:0] c_state_resp = 2'd2;

  logic [1:0]               r_state;
  logic [2:0]               r_op;
  logic [addr_width_lp-1:0] r_addr;
  logic [data_width_p-1:0]  r_data;
  logic [data_width_p-1:0]  r_resp_data;
  logic                     r_err;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_rmw;
  logic                     w_unsupported;
  logic                     w_mem_v;
  logic [data_width_p-1:0]  w_new;

  // Only one request in flight: accept solely from IDLE and never under reset.
  assign w_ready  = (r_state == c_state_idle) && !reset_i;
  assign w_accept = v_i && w_ready;
  assign ready_o  = w_ready;

  assign v_o    = (r_state == c_state_resp);
  assign data_o = r_resp_data;
  assign err_o  = r_err;

  // Classify the latched op: which ops write back, and which are unsupported.
  always_comb begin
    w_rmw         = 1'b0;
    w_unsupported = 1'b0;
    case (r_op)
      c_op_swap, c_op_add, c_op_or, c_op_and: w_rmw = 1'b1;
`ifdef BSG_MANYCORE_BMEM_AMO_MINMAX_EN
      c_op_min, c_op_max: w_rmw = 1'b1;
`else
      c_op_min, c_op_max: w_unsupported = 1'b1;
`endif
      default: w_rmw = 1'b0;
    endcase
  end

  // AMO new value computed from the old word returned by the SRAM.
  always_comb begin
    w_new = mem_data_i;
    case (r_op)
      c_op_swap: w_new = r_data;
      c_op_add:  w_new = mem_data_i + r_data;
      c_op_or:   w_new = mem_data_i | r_data;
      c_op_and:  w_new = mem_data_i & r_data;
`ifdef BSG_MANYCORE_BMEM_AMO_MINMAX_EN
      c_op_min:  w_new = ($signed(mem_data_i) < $signed(r_data)) ? mem_data_i : r_data;
      c_op_max:  w_new = ($signed(mem_data_i) > $signed(r_data)) ? mem_data_i : r_data;
`endif
      default:   w_new = mem_data_i;
    endcase
  end

  // SRAM port: request access straight from the inputs in IDLE, AMO write-back in ISSUE.
  always_comb begin
    w_mem_v    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = addr_i;
    mem_data_o = data_i;
    mem_mask_o = {mask_width_lp{1'b1}};
    case (r_state)
      c_state_idle: begin
        w_mem_v = v_i;
        if (op_i == c_op_store) begin
          mem_w_o    = 1'b1;
          mem_mask_o = mask_i;
        end
      end
      c_state_issue: begin
        w_mem_v    = w_rmw;
        mem_w_o    = 1'b1;
        mem_addr_o = r_addr;
        mem_data_o = w_new;
      end
      default: w_mem_v = 1'b0;
    endcase
  end

  // Reset suppresses any SRAM access, including a pending AMO write-back.
  assign mem_v_o = w_mem_v && !reset_i;

  // Control FSM with operand latching and response capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= c_state_idle;
      r_op        <= c_op_load;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp_data <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (w_accept) begin
            r_op    <= op_i;
            r_addr  <= addr_i;
            r_data  <= data_i;
            r_state <= c_state_issue;
          end
        end
        c_state_issue: begin
          r_resp_data <= (r_op == c_op_store) ? '0 : mem_data_i;
          r_err       <= w_unsupported;
          r_state     <= c_state_resp;
        end
        c_state_resp: begin
          if (ready_i) begin
            r_state <= c_state_idle;
          end
        end
        default: r_state <= c_state_idle;
      endcase
    end
  end

endmodule

`default_nettype wire
